// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the program RAM and the execution driver.
// The master modport is the fetch unit itself; slave is its environment.
interface instruction_fetch_unit_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int OPCODE_WIDTH  = 8
);
    logic                            enable;
    logic                            jump_valid;
    logic [ADDRESS_WIDTH-1:0]        jump_address;
    logic                            pram_enable;
    logic                            pram_rw;
    logic [ADDRESS_WIDTH-1:0]        pram_address;
    logic [DATA_WIDTH-1:0]           pram_data_in;
    logic                            instr_valid;
    logic                            instr_ready;
    logic [DATA_WIDTH-1:0]           instruction;
    logic [OPCODE_WIDTH-1:0]         opcode;
    logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand;
    logic [ADDRESS_WIDTH-1:0]        instr_pc;

    modport master (
        input  enable, jump_valid, jump_address, pram_data_in, instr_ready,
        output pram_enable, pram_rw, pram_address, instr_valid,
               instruction, opcode, operand, instr_pc
    );

    modport slave (
        output enable, jump_valid, jump_address, pram_data_in, instr_ready,
        input  pram_enable, pram_rw, pram_address, instr_valid,
               instruction, opcode, operand, instr_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches instruction words from a program RAM with one-cycle registered read
// latency and holds each one until the execution driver accepts it.
module instruction_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 16,
    parameter int                       OPCODE_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input logic                      clock,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] VALID   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0]    instruction_q, instruction_d;
    logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_valid_d = instr_valid_q;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                instruction_d = bus.pram_data_in;
                instr_pc_d    = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDRESS_WIDTH'(1);
                instr_valid_d = 1'b1;
                state_d       = VALID;
            end
            default: begin
                if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = bus.enable ? REQUEST : IDLE;
                end
            end
        endcase

        // A redirect overrides everything above, including a pending capture,
        // so the in-flight RAM word never reaches the instruction register.
        if (bus.jump_valid) begin
            fetch_pc_d    = bus.jump_address;
            instr_valid_d = 1'b0;
            instruction_d = instruction_q;
            instr_pc_d    = instr_pc_q;
            state_d       = bus.enable ? REQUEST : IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign bus.pram_enable  = (state_q == REQUEST);
    assign bus.pram_rw      = 1'b0;
    assign bus.pram_address = fetch_pc_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.instruction  = instruction_q;
    assign bus.opcode       = instruction_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.operand      = instruction_q[DATA_WIDTH-OPCODE_WIDTH-1:0];
    assign bus.instr_pc     = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural program RAM
// that has one cycle of registered read latency.
module tb_instruction_fetch_unit;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   ticks;
    logic [15:0] mem [0:65535];

    instruction_fetch_unit_if #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .OPCODE_WIDTH(8)
    ) bus ();

    instruction_fetch_unit #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .OPCODE_WIDTH(8),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (bus.pram_enable) begin
            bus.pram_data_in <= mem[bus.pram_address];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advances until instr_valid is seen or the budget runs out.
    task automatic wait_valid(input string tag, input int budget, output int count);
        count = 0;
        do begin
            tick();
            count++;
        end while (!bus.instr_valid && count < budget);
        check_output({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;

        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.jump_valid   = 1'b0;
        bus.jump_address = '0;
        bus.instr_ready  = 1'b0;
        tick();
        tick();
        check_output("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("rst_pram_en", 32'(bus.pram_enable), 32'd0);
        check_output("rst_instr", 32'(bus.instruction), 32'd0);
        check_output("rst_pc", 32'(bus.instr_pc), 32'd0);
        check_output("rst_rw", 32'(bus.pram_rw), 32'd0);

        $display("[TB] single fetch and hold");
        mem[0] = 16'h0305;
        reset      = 1'b0;
        bus.enable = 1'b1;
        tick();
        check_output("t1_req_en", 32'(bus.pram_enable), 32'd1);
        check_output("t1_req_addr", 32'(bus.pram_address), 32'h0000);
        check_output("t1_req_rw", 32'(bus.pram_rw), 32'd0);
        tick();
        check_output("t1_cap_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t1_cap_en", 32'(bus.pram_enable), 32'd0);
        tick();
        check_output("t1_valid", 32'(bus.instr_valid), 32'd1);
        check_output("t1_instr", 32'(bus.instruction), 32'h0305);
        check_output("t1_opcode", 32'(bus.opcode), 32'h03);
        check_output("t1_operand", 32'(bus.operand), 32'h05);
        check_output("t1_pc", 32'(bus.instr_pc), 32'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("t1_hold", {15'd0, bus.instr_valid, bus.instruction},
                         {15'd0, 1'b1, 16'h0305});
        end

        $display("[TB] streaming four words");
        reset = 1'b1;
        tick();
        mem[0] = 16'h0101;
        mem[1] = 16'h0202;
        mem[2] = 16'h0303;
        mem[3] = 16'h0404;
        reset           = 1'b0;
        bus.enable      = 1'b1;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("t2_wait", 10, ticks);
            check_output("t2_interval", 32'(ticks), 32'd3);
            check_output("t2_pc", 32'(bus.instr_pc), 32'(k));
            check_output("t2_instr", 32'(bus.instruction), 32'(16'h0101 * (k + 1)));
        end

        $display("[TB] redirect during capture");
        reset = 1'b1;
        tick();
        mem[16'h0020] = 16'hAB20;
        reset = 1'b0;
        wait_valid("t3_first", 10, ticks);
        check_output("t3_first_pc", 32'(bus.instr_pc), 32'h0000);
        tick();
        check_output("t3_req1_addr", 32'(bus.pram_address), 32'h0001);
        tick();
        check_output("t3_cap1_en", 32'(bus.pram_enable), 32'd0);
        bus.jump_valid   = 1'b1;
        bus.jump_address = 16'h0020;
        tick();
        bus.jump_valid = 1'b0;
        check_output("t3_no_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t3_kept_instr", 32'(bus.instruction), 32'h0101);
        check_output("t3_jump_addr", {15'd0, bus.pram_enable, bus.pram_address},
                     {15'd0, 1'b1, 16'h0020});
        wait_valid("t3_target", 10, ticks);
        check_output("t3_latency", 32'(ticks), 32'd2);
        check_output("t3_pc", 32'(bus.instr_pc), 32'h0020);
        check_output("t3_instr", 32'(bus.instruction), 32'hAB20);

        $display("[TB] address wrap");
        mem[16'hFFFF]    = 16'hFEED;
        bus.jump_valid   = 1'b1;
        bus.jump_address = 16'hFFFF;
        tick();
        bus.jump_valid  = 1'b0;
        bus.instr_ready = 1'b0;
        check_output("t4_jump_over_hs", 32'(bus.instr_valid), 32'd0);
        check_output("t4_req_addr", 32'(bus.pram_address), 32'hFFFF);
        wait_valid("t4_wait", 10, ticks);
        check_output("t4_pc", 32'(bus.instr_pc), 32'hFFFF);
        check_output("t4_opcode", 32'(bus.opcode), 32'hFE);
        check_output("t4_operand", 32'(bus.operand), 32'hED);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check_output("t4_wrap_addr", {15'd0, bus.pram_enable, bus.pram_address},
                     {15'd0, 1'b1, 16'h0000});

        $display("[TB] enable dropped in request");
        bus.enable = 1'b0;
        tick();
        tick();
        check_output("t5_valid", 32'(bus.instr_valid), 32'd1);
        check_output("t5_pc", 32'(bus.instr_pc), 32'h0000);
        check_output("t5_instr", 32'(bus.instruction), 32'h0101);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check_output("t5_after_hs", {30'd0, bus.instr_valid, bus.pram_enable}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t5_idle_en", 32'(bus.pram_enable), 32'd0);
        end
        bus.enable = 1'b1;
        tick();
        check_output("t5_resume", {15'd0, bus.pram_enable, bus.pram_address},
                     {15'd0, 1'b1, 16'h0001});

        $display("[TB] reset beats redirect");
        tick();
        tick();
        check_output("t6_valid", 32'(bus.instr_valid), 32'd1);
        check_output("t6_instr", 32'(bus.instruction), 32'h0202);
        reset            = 1'b1;
        bus.jump_valid   = 1'b1;
        bus.jump_address = 16'h0055;
        bus.instr_ready  = 1'b1;
        tick();
        check_output("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t6_rst_en", 32'(bus.pram_enable), 32'd0);
        check_output("t6_rst_instr", {bus.instr_pc, bus.instruction}, 32'd0);
        reset           = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        check_output("t6_vector", {15'd0, bus.pram_enable, bus.pram_address},
                     {15'd0, 1'b1, 16'h0000});

        $display("[TB] redirect with enable low");
        bus.enable       = 1'b0;
        bus.jump_valid   = 1'b1;
        bus.jump_address = 16'h0040;
        tick();
        bus.jump_valid = 1'b0;
        check_output("t7_idle_en", 32'(bus.pram_enable), 32'd0);
        tick();
        check_output("t7_still_idle", 32'(bus.pram_enable), 32'd0);
        bus.enable = 1'b1;
        tick();
        check_output("t7_resume", {15'd0, bus.pram_enable, bus.pram_address},
                     {15'd0, 1'b1, 16'h0040});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
